// File: rtl/usr_c2h0_gen_pkg.sv
// Shared definitions for the C2H channel-0 pattern source and the H2C channel-0 checker.
// Holds the FSM encoding and the keep helpers both sides rely on.
package usr_c2h0_gen_pkg;

    localparam int C2H_DATA_W = 64;
    localparam int C2H_KEEP_W = C2H_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } c2h_state_t;

    // Byte enables of a packet's final beat; rem==0 means that beat is full.
    function automatic logic [7:0] rem_to_keep(input logic [2:0] rem);
        logic [7:0] keep;
        case (rem)
            3'd1:    keep = 8'h01;
            3'd2:    keep = 8'h03;
            3'd3:    keep = 8'h07;
            3'd4:    keep = 8'h0f;
            3'd5:    keep = 8'h1f;
            3'd6:    keep = 8'h3f;
            3'd7:    keep = 8'h7f;
            default: keep = 8'hff;
        endcase
        return keep;
    endfunction

    function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/usr_c2h0_gen.sv
// C2H channel-0 test-pattern source: byte-incrementing AXI4-Stream packets of
// programmable length and count, with a completion interrupt request.
module usr_c2h0_gen
    import usr_c2h0_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  usr_clk,
    input  logic                  usr_rst_n,
    input  logic                  usr_c2h0r_run_i,
    input  logic                  s0_axis_c2h_rst_i,
    input  logic [31:0]           usr_c2h0_len_i,
    input  logic [15:0]           usr_c2h0_pkt_num_i,
    output logic [DATA_WIDTH-1:0] s0_axis_c2h_tdata_o,
    output logic [KEEP_WIDTH-1:0] s0_axis_c2h_tkeep_o,
    output logic                  s0_axis_c2h_tlast_o,
    output logic                  s0_axis_c2h_tvalid_o,
    input  logic                  s0_axis_c2h_tready_i,
    output logic                  usr_c2h0_done_o,
    output logic [31:0]           usr_c2h0_pkt_cnt_o,
    output logic                  usr_c2h0irq_req_o,
    input  logic                  usr_c2h0irq_ack_i
);

    c2h_state_t state_reg, state_next;

    logic                  run_d1_reg;
    logic [15:0]           pkt_num_reg;
    logic [28:0]           last_idx_reg;
    logic [2:0]            rem_reg;
    logic [31:0]           pkt_cnt_reg;
    logic                  done_reg;
    logic                  done_d1_reg;
    logic                  irq_reg;

    logic [7:0]            bc_reg, bc_next;
    logic [28:0]           idx_reg, idx_next;
    logic                  tvalid_reg, tvalid_next;
    logic                  tlast_reg, tlast_next;
    logic [KEEP_WIDTH-1:0] tkeep_reg, tkeep_next;
    logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;

    logic        abort;
    logic        run_rise;
    logic        hs;
    logic        pkt_end;
    logic        final_pkt;
    logic [28:0] load_last_idx;
    logic [28:0] cur_last_idx;
    logic [2:0]  cur_rem;
    logic [7:0]  bc_adv;

    assign abort    = (run_d1_reg & ~usr_c2h0r_run_i) | s0_axis_c2h_rst_i;
    assign run_rise = usr_c2h0r_run_i & ~run_d1_reg;
    assign hs       = tvalid_reg & s0_axis_c2h_tready_i;
    assign pkt_end  = (state_reg == ST_SEND) & hs & tlast_reg;

    // Index of the last beat, ceil(len/8)-1, without needing a 30-bit beat count.
    assign load_last_idx = usr_c2h0_len_i[31:3] - {28'd0, (usr_c2h0_len_i[2:0] == 3'd0)};
    assign final_pkt     = (pkt_num_reg != 16'd0) &&
                           ((pkt_cnt_reg + 32'd1) == {16'd0, pkt_num_reg});

    // ---------------- FSM ----------------
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (run_rise) state_next = ST_LOAD;
                ST_LOAD: state_next = (usr_c2h0_len_i == 32'd0) ? ST_DONE : ST_SEND;
                ST_SEND: if (pkt_end && final_pkt) state_next = ST_DONE;
                ST_DONE: state_next = ST_DONE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- run control, counters, interrupt ----------------
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            run_d1_reg   <= 1'b0;
            pkt_num_reg  <= 16'd0;
            last_idx_reg <= 29'd0;
            rem_reg      <= 3'd0;
            pkt_cnt_reg  <= 32'd0;
            done_reg     <= 1'b0;
            done_d1_reg  <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            run_d1_reg  <= usr_c2h0r_run_i;
            done_reg    <= (state_next == ST_DONE);
            done_d1_reg <= done_reg;
            if (state_reg == ST_LOAD && !abort) begin
                pkt_num_reg  <= usr_c2h0_pkt_num_i;
                last_idx_reg <= load_last_idx;
                rem_reg      <= usr_c2h0_len_i[2:0];
            end
            if (abort) begin
                pkt_cnt_reg <= 32'd0;
            end else if (pkt_end) begin
                pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
            end
            // A new completion outranks an acknowledge arriving in the same cycle.
            if (done_reg && !done_d1_reg) begin
                irq_reg <= 1'b1;
            end else if (usr_c2h0irq_ack_i) begin
                irq_reg <= 1'b0;
            end
        end
    end

    // ---------------- beat generator ----------------
    logic                  beat_load;
    logic [7:0]            beat_bc;
    logic                  beat_last;
    logic [KEEP_WIDTH-1:0] beat_keep;
    logic [DATA_WIDTH-1:0] beat_data;

    // While in LOAD the latched packet shape is not yet valid, so use the inputs.
    assign cur_last_idx = (state_reg == ST_LOAD) ? load_last_idx : last_idx_reg;
    assign cur_rem      = (state_reg == ST_LOAD) ? usr_c2h0_len_i[2:0] : rem_reg;
    assign bc_adv       = bc_reg + {4'd0, keep_popcount(tkeep_reg)};
    assign beat_last    = (idx_next == cur_last_idx);
    assign beat_keep    = beat_last ? rem_to_keep(cur_rem) : {KEEP_WIDTH{1'b1}};

    generate
        for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
            assign beat_data[gi*8 +: 8] = beat_keep[gi] ? (beat_bc + 8'(gi)) : 8'h00;
        end
    endgenerate

    always_comb begin
        beat_load   = 1'b0;
        beat_bc     = bc_reg;
        bc_next     = bc_reg;
        idx_next    = idx_reg;
        tvalid_next = tvalid_reg;
        if (abort) begin
            bc_next     = 8'd0;
            idx_next    = 29'd0;
            tvalid_next = 1'b0;
        end else if (state_reg == ST_LOAD) begin
            idx_next = 29'd0;
            if (usr_c2h0_len_i != 32'd0) begin
                beat_load   = 1'b1;
                tvalid_next = 1'b1;
            end
        end else if (state_reg == ST_SEND && hs) begin
            bc_next = bc_adv;
            if (tlast_reg && final_pkt) begin
                tvalid_next = 1'b0;
            end else begin
                beat_load = 1'b1;
                beat_bc   = bc_adv;
                idx_next  = tlast_reg ? 29'd0 : idx_reg + 29'd1;
            end
        end
    end

    always_comb begin
        tdata_next = tdata_reg;
        tkeep_next = tkeep_reg;
        tlast_next = tlast_reg;
        if (beat_load) begin
            tdata_next = beat_data;
            tkeep_next = beat_keep;
            tlast_next = beat_last;
        end else if (!tvalid_next) begin
            tlast_next = 1'b0;
        end
    end

    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            bc_reg     <= 8'd0;
            idx_reg    <= 29'd0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            tkeep_reg  <= '0;
            tdata_reg  <= '0;
        end else begin
            bc_reg     <= bc_next;
            idx_reg    <= idx_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
            tkeep_reg  <= tkeep_next;
            tdata_reg  <= tdata_next;
        end
    end

    assign s0_axis_c2h_tdata_o  = tdata_reg;
    assign s0_axis_c2h_tkeep_o  = tkeep_reg;
    assign s0_axis_c2h_tlast_o  = tlast_reg;
    assign s0_axis_c2h_tvalid_o = tvalid_reg;
    assign usr_c2h0_done_o      = done_reg;
    assign usr_c2h0_pkt_cnt_o   = pkt_cnt_reg;
    assign usr_c2h0irq_req_o    = irq_reg;

endmodule

// File: tb/tb_usr_c2h0_gen.sv
// Directed bench for usr_c2h0_gen: a byte-stream model predicts every beat,
// and hand-computed literals pin key beats, done/irq timing and counters.
module tb_usr_c2h0_gen;

    logic        usr_clk;
    logic        usr_rst_n;
    logic        run;
    logic        c2h_rst;
    logic [31:0] len;
    logic [15:0] pkt_num;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic        done;
    logic [31:0] pkt_cnt;
    logic        irq;
    logic        ack;

    usr_c2h0_gen #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
        .usr_clk              (usr_clk),
        .usr_rst_n            (usr_rst_n),
        .usr_c2h0r_run_i      (run),
        .s0_axis_c2h_rst_i    (c2h_rst),
        .usr_c2h0_len_i       (len),
        .usr_c2h0_pkt_num_i   (pkt_num),
        .s0_axis_c2h_tdata_o  (tdata),
        .s0_axis_c2h_tkeep_o  (tkeep),
        .s0_axis_c2h_tlast_o  (tlast),
        .s0_axis_c2h_tvalid_o (tvalid),
        .s0_axis_c2h_tready_i (tready),
        .usr_c2h0_done_o      (done),
        .usr_c2h0_pkt_cnt_o   (pkt_cnt),
        .usr_c2h0irq_req_o    (irq),
        .usr_c2h0irq_ack_i    (ack)
    );

    initial usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] hs_log[$];
    logic [7:0]  last_hs_k;
    int          vec_cnt = 0;
    int          mis_cnt = 0;

    // A run always begins at byte 0; the stream is cut into 8-byte beats per packet.
    task automatic model_run(input int plen, input int num);
        int    pkts;
        int    b;
        int    n;
        beat_t bt;
        pkts = (num == 0) ? 40 : num;
        b = 0;
        for (int p = 0; p < pkts; p++) begin
            for (int off = 0; off < plen; off += 8) begin
                n = (plen - off > 8) ? 8 : plen - off;
                bt.d = 64'd0;
                bt.k = 8'd0;
                for (int i = 0; i < n; i++) begin
                    bt.d[i*8 +: 8] = 8'((b + i) % 256);
                    bt.k[i] = 1'b1;
                end
                bt.l = (off + 8 >= plen);
                exp_q.push_back(bt);
                b += n;
            end
        end
    endtask

    always @(negedge usr_clk) begin
        beat_t got;
        if (usr_rst_n && tvalid) begin
            got = {tdata, tkeep, tlast};
            vec_cnt++;
            if (exp_q.size() == 0) begin
                mis_cnt++;
                $display("FAIL beat_unexpected: got tdata=%h tkeep=%h tlast=%b, required no beat",
                         tdata, tkeep, tlast);
            end else begin
                if (got !== exp_q[0]) begin
                    mis_cnt++;
                    $display("FAIL beat: got tdata=%h tkeep=%h tlast=%b, required tdata=%h tkeep=%h tlast=%b",
                             tdata, tkeep, tlast, exp_q[0].d, exp_q[0].k, exp_q[0].l);
                end
                if (tready) begin
                    hs_log.push_back(tdata);
                    last_hs_k = tkeep;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vec_cnt++;
        if (act !== req) begin
            mis_cnt++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end else begin
            $display("ok   %s = %h", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge usr_clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic end_run_and_ack();
        run = 1'b0;
        tick();
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("irq_cleared", 64'(irq), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        usr_rst_n = 1'b0;
        run       = 1'b0;
        c2h_rst   = 1'b0;
        len       = 32'd0;
        pkt_num   = 16'd0;
        tready    = 1'b1;
        ack       = 1'b0;
        #12;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        @(negedge usr_clk);
        usr_rst_n = 1'b1;
        tick();
        tick();

        // len=20, one packet: exact beat and done/irq timing
        len = 32'd20; pkt_num = 16'd1;
        model_run(20, 1);
        run = 1'b1;
        tick();
        chk("t1_cyc1_tvalid", 64'(tvalid), 64'd0);
        tick();
        chk("t1_b0_tvalid", 64'(tvalid), 64'd1);
        chk("t1_b0_tdata", tdata, 64'h0706050403020100);
        chk("t1_b0_tkeep", 64'(tkeep), 64'hff);
        tick();
        chk("t1_b1_tdata", tdata, 64'h0F0E0D0C0B0A0908);
        tick();
        chk("t1_b2_tdata", tdata, 64'h0000000013121110);
        chk("t1_b2_tkeep", 64'(tkeep), 64'h0f);
        chk("t1_b2_tlast", 64'(tlast), 64'd1);
        tick();
        chk("t1_done_tvalid", 64'(tvalid), 64'd0);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_irq_not_yet", 64'(irq), 64'd0);
        tick();
        chk("t1_irq", 64'(irq), 64'd1);
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        run = 1'b0;
        tick();
        chk("t1_abort_done", 64'(done), 64'd0);
        chk("t1_abort_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("t1_abort_irq_kept", 64'(irq), 64'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t1_irq_acked", 64'(irq), 64'd0);

        // len=16, two packets: second packet continues at byte 0x10
        hs_log.delete();
        len = 32'd16; pkt_num = 16'd2;
        model_run(16, 2);
        run = 1'b1;
        wait_done(50);
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);
        chk("t2_beats", 64'(hs_log.size()), 64'd4);
        chk("t2_pkt2_first", hs_log.size() > 2 ? hs_log[2] : 64'd0, 64'h1716151413121110);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        end_run_and_ack();

        // len=300: byte counter wraps inside the packet
        hs_log.delete();
        len = 32'd300; pkt_num = 16'd1;
        model_run(300, 1);
        run = 1'b1;
        wait_done(100);
        chk("t3_beats", 64'(hs_log.size()), 64'd38);
        chk("t3_b31", hs_log.size() > 32 ? hs_log[31] : 64'd0, 64'hFFFEFDFCFBFAF9F8);
        chk("t3_b32_wrap", hs_log.size() > 32 ? hs_log[32] : 64'd0, 64'h0706050403020100);
        chk("t3_last_data", hs_log.size() > 37 ? hs_log[37] : 64'd0, 64'h000000002B2A2928);
        chk("t3_last_keep", 64'(last_hs_k), 64'h0f);
        end_run_and_ack();

        // random back-pressure, 3 packets of 45 bytes
        len = 32'd45; pkt_num = 16'd3;
        model_run(45, 3);
        run = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            tready = 1'($urandom_range(0, 1));
            tick();
        end
        tready = 1'b1;
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd3);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        end_run_and_ack();

        // continuous mode aborted by run falling mid-packet, then restart
        len = 32'd16; pkt_num = 16'd0;
        model_run(16, 0);
        run = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("t5_pkt_cnt_mid", 64'(pkt_cnt), 64'd2);
        chk("t5_tvalid_mid", 64'(tvalid), 64'd1);
        run = 1'b0;
        tick();
        exp_q.delete();
        chk("t5_abort_tvalid", 64'(tvalid), 64'd0);
        chk("t5_abort_pkt_cnt", 64'(pkt_cnt), 64'd0);
        len = 32'd8; pkt_num = 16'd1;
        model_run(8, 1);
        run = 1'b1;
        tick();
        tick();
        chk("t5_restart_tdata", tdata, 64'h0706050403020100);
        chk("t5_restart_tlast", 64'(tlast), 64'd1);
        tick();
        chk("t5_restart_done", 64'(done), 64'd1);
        chk("t5_restart_pkt_cnt", 64'(pkt_cnt), 64'd1);
        end_run_and_ack();

        // stream reset aborts mid-packet
        len = 32'd24; pkt_num = 16'd0;
        model_run(24, 0);
        run = 1'b1;
        tick();
        tick();
        tick();
        c2h_rst = 1'b1;
        tick();
        c2h_rst = 1'b0;
        exp_q.delete();
        chk("t6_rst_tvalid", 64'(tvalid), 64'd0);
        run = 1'b0;
        tick();

        // len=0: straight to DONE; ack colliding with set loses
        len = 32'd0; pkt_num = 16'd1;
        run = 1'b1;
        tick();
        chk("t7_cyc1_done", 64'(done), 64'd0);
        tick();
        chk("t7_done", 64'(done), 64'd1);
        chk("t7_tvalid", 64'(tvalid), 64'd0);
        ack = 1'b1;
        tick();
        chk("t7_irq_set_wins", 64'(irq), 64'd1);
        ack = 1'b0;
        tick();
        chk("t7_irq_held", 64'(irq), 64'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t7_irq_acked", 64'(irq), 64'd0);
        run = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/usr_c2h0_gen.md
# usr_c2h0_gen

C2H channel-0 test-pattern source. It drives the DMA core's card-to-host AXI4-Stream slave port with byte-incrementing packets of programmable length and count. The pattern is byte-for-byte identical to the one the H2C channel-0 checker expects, so the same host buffer can be looped back. It sits beside the H2C checker in the user application, runs on the same run/reset controls, and raises a completion interrupt request.

## Interface
Parameters:
- DATA_WIDTH, 64, stream data width; only 64 is supported.
- KEEP_WIDTH, 8, equal to DATA_WIDTH/8.

Ports:
- usr_clk  in  1  user clock.
- usr_rst_n  in  1  reset; asynchronous, active-low.
- usr_c2h0r_run_i  in  1  run level. Rising edge starts a run; falling edge aborts or ends it.
- s0_axis_c2h_rst_i  in  1  synchronous stream reset from the DMA core.
- usr_c2h0_len_i  in  32  bytes per packet; sampled at start.
- usr_c2h0_pkt_num_i  in  16  packets per run; 0 means continuous. Sampled at start.
- s0_axis_c2h_tdata_o  out  DATA_WIDTH  stream data.
- s0_axis_c2h_tkeep_o  out  KEEP_WIDTH  byte enables.
- s0_axis_c2h_tlast_o  out  1  last beat of packet.
- s0_axis_c2h_tvalid_o  out  1  beat valid.
- s0_axis_c2h_tready_i  in  1  sink ready.
- usr_c2h0_done_o  out  1  all packets sent.
- usr_c2h0_pkt_cnt_o  out  32  packets completed in this run.
- usr_c2h0irq_req_o  out  1  interrupt request.
- usr_c2h0irq_ack_i  in  1  interrupt acknowledge.

## Operation
- Outputs are all registered. Reset value of every output is 0.
- Abort condition: run falling edge OR s0_axis_c2h_rst_i.
  - FSM returns to IDLE.
  - tvalid, tlast, done and pkt_cnt clear to 0.
  - The byte counter clears to 0.
  - irq_req is unaffected.
  - tvalid may drop without a handshake; this is accepted because the DMA channel is reset alongside.
- FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE -> LOAD on run rising edge (run_i=1 while the registered run_d1=0).
  - LOAD: latch len and pkt_num; compute beats = ceil(len/8) and rem = len[2:0].
    - len==0 -> DONE with no beats sent.
    - Otherwise -> SEND.
  - SEND: present beats; advance only on handshake (tvalid & tready).
    - On a tlast handshake, pkt_cnt increments.
    - If pkt_num!=0 and pkt_cnt+1==pkt_num -> DONE.
    - Otherwise the next packet's first beat is presented in the following cycle. There are no gap cycles.
  - DONE: done_o=1 and tvalid=0; stays there until the abort condition.
- Data pattern:
  - An 8-bit byte counter bc, modulo 256, continues across packets.
  - Beat byte i = bc+i for enabled lanes; disabled lanes are 0.
  - After each handshake, bc += popcount(tkeep).
- tkeep: 8'hff on every beat except the last. The last beat uses 8'hff if rem==0, else (1<<rem)-1.
- tlast is set on beat index beats-1 of each packet.
- Interrupt:
  - irq_req is set on the cycle after entering DONE.
  - It clears on irq_ack_i=1.
  - If set and ack occur in the same cycle, set wins.

## Timing
- Cycle 0: first edge sampling run_i=1. Cycle 1: LOAD. Cycle 2: tvalid=1 with first beat.
- With tready held high, the sustained rate is one beat per cycle, including across packet boundaries.
- tdata, tkeep and tlast hold stable while tvalid=1 and tready=0.
- Handshake on cycle n: the next beat appears on cycle n+1.
- Final tlast handshake on cycle n: tvalid=0 and done_o=1 on n+1; irq_req=1 on n+2.
- The beat counter is 29 bits; pkt_cnt wraps at 2^32 in continuous mode.
- Mid-run changes to len_i/pkt_num_i have no effect until the next start.
- A run rising edge while not in IDLE cannot occur, since a falling edge always precedes it.

## Structure
- Shared package holds:
  - the FSM state encoding (2 bits);
  - the rem->tkeep function (lookup) and the popcount-of-keep function.
  - The H2C checker reuses the popcount function.
- Single module, no sub-modules. The beat generator (bc, keep, tlast) is a clearly separated always-block group.

## Test plan
- len=20, pkt_num=1, tready=1:
  - 3 beats: tdata 0x0706050403020100, 0x0F0E0D0C0B0A0908, then 0x0000000013121110 with tkeep=0x0f and tlast=1.
  - done=1 next cycle; irq_req the cycle after.
- len=16, pkt_num=2: 4 beats, tlast on beats 2 and 4; the second packet starts with byte 0x10; pkt_cnt=2.
- len=300, pkt_num=1:
  - byte 255 is followed by byte 0x00 (wrap);
  - last beat tkeep=0x0f with bytes 0x28..0x2B.
- tready toggled randomly: outputs stable while stalled; the byte stream is unbroken.
- Run falls mid-packet: tvalid=0 next cycle. A new run restarts at byte 0x00 with pkt_cnt=0.
- len=0: DONE at cycle 2 with no tvalid. Ack in the same cycle as set: irq_req stays 1; a later ack clears it.
